uart_fifo_core: RTL and testbench

Parametrised, FIFO-buffered UART transceiver that succeeds the single-frame UART core in the equipo7 tile. It adds:
- a programmable baud divider;
- runtime frame format: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits;
- mid-bit sampling with false-start rejection;
- separate TX and RX FIFOs with valid/ready handshakes, and framing, parity and overflow reporting.

It sits between the tile's pin wrapper and any host-side logic.

---
 rtl/uart_pkg.sv | 55 +++++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_fifo_core.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, frame format and RX entry layout.
// Build with UART_PARITY_EN defined to add the PARITY states.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic [1:0] len;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } uart_cfg_t;

  localparam int RX_W    = 10;
  localparam int FRM_BIT = 9;
  localparam int PAR_BIT = 8;

  function automatic logic [7:0] len_mask(
    input logic [1:0] len
  );
    unique case (len)
      2'd0:    len_mask = 8'h1f;
      2'd1:    len_mask = 8'h3f;
      2'd2:    len_mask = 8'h7f;
      default: len_mask = 8'hff;
    endcase
  endfunction

  function automatic logic par_bit(
    input logic [7:0] d,
    input logic [1:0] len,
    input logic       odd
  );
    par_bit = (^(d & len_mask(len))) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO with count-based flags.
// A pop frees a slot for a push in the same cycle, even when full.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rptr];

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (!do_push && do_pop)
        cnt <= cnt - 1'b1;
    end
  end

  // storage, masked by empty at the consumer
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: FIFO-buffered UART with runtime frame format.
// Build with UART_PARITY_EN defined to add parity send/check.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OVS   = 16,
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_len,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_par_err,
  output logic             rx_frm_err,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_ovf,
  input  logic             rx_ovf_clr,
  output logic             tx_sn,
  input  logic             rx_sn,
  output logic             tx_busy
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);

  uart_cfg_t cfg_in;

  // frame format as seen at frame start
  always_comb begin
    cfg_in.len     = cfg_len;
`ifdef UART_PARITY_EN
    cfg_in.par_en  = cfg_par_en;
    cfg_in.par_odd = cfg_par_odd;
`else
    cfg_in.par_en  = 1'b0;
    cfg_in.par_odd = 1'b0;
`endif
    cfg_in.stop2   = cfg_stop2;
  end

  // ---------------- TX ----------------
  tx_state_t        tx_st;
  uart_cfg_t        tx_cfg;
  logic [DIV_W-1:0] tx_div;
  logic [DIV_W-1:0] tx_dcnt;
  logic [TW-1:0]    tx_tcnt;
  logic [7:0]       tx_sh;
  logic [2:0]       tx_bcnt;
  logic             tx_scnd;
  logic [7:0]       txf_rdata;
  logic             txf_full;
  logic             txf_empty;
  logic             tx_dend;
  logic             tx_bend;
  logic             tx_last;
  logic             tx_stop_done;
  logic             tx_pop;
`ifdef UART_PARITY_EN
  logic             tx_par;
`endif

  assign tx_dend = (tx_dcnt == tx_div);
  assign tx_bend = tx_dend && (tx_tcnt == T_LAST);
  assign tx_last = (tx_bcnt == ({1'b0, tx_cfg.len} + 3'd4));
  assign tx_stop_done = tx_bend &&
                        (!tx_cfg.stop2 || tx_scnd);
  assign tx_pop = !txf_empty &&
                  ((tx_st == TX_IDLE) ||
                   (tx_st == TX_STOP && tx_stop_done));
  assign tx_ready = !txf_full;
  assign tx_busy  = (tx_st != TX_IDLE) || !txf_empty;

  uart_sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_txf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (txf_rdata),
    .full    (txf_full),
    .empty   (txf_empty)
  );

  // TX bit timing, restarted from zero on every frame load
  always_ff @(posedge clk) begin
    if (!rst_n || tx_pop || tx_st == TX_IDLE) begin
      tx_dcnt <= '0;
      tx_tcnt <= '0;
    end else if (tx_dend) begin
      tx_dcnt <= '0;
      tx_tcnt <= (tx_tcnt == T_LAST) ? '0
                                     : tx_tcnt + 1'b1;
    end else begin
      tx_dcnt <= tx_dcnt + 1'b1;
    end
  end

  // TX frame sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_st   <= TX_IDLE;
      tx_cfg  <= '0;
      tx_div  <= '0;
      tx_sh   <= '0;
      tx_bcnt <= '0;
      tx_scnd <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par  <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st   <= TX_START;
      tx_cfg  <= cfg_in;
      tx_div  <= cfg_div;
      tx_sh   <= txf_rdata;
      tx_bcnt <= '0;
      tx_scnd <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par  <= par_bit(txf_rdata, cfg_in.len,
                         cfg_in.par_odd);
`endif
    end else begin
      unique case (tx_st)
        TX_START: if (tx_bend) tx_st <= TX_DATA;
        TX_DATA: begin
          if (tx_bend) begin
            tx_sh   <= tx_sh >> 1;
            tx_bcnt <= tx_bcnt + 1'b1;
`ifdef UART_PARITY_EN
            if (tx_last)
              tx_st <= tx_cfg.par_en ? TX_PAR : TX_STOP;
`else
            if (tx_last) tx_st <= TX_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        TX_PAR: if (tx_bend) tx_st <= TX_STOP;
`endif
        TX_STOP: begin
          if (tx_stop_done)
            tx_st <= TX_IDLE;
          else if (tx_bend)
            tx_scnd <= 1'b1;
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  // line level registered one clock behind the sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sn <= 1'b1;
    end else begin
      unique case (tx_st)
        TX_START: tx_sn <= 1'b0;
        TX_DATA:  tx_sn <= tx_sh[0];
`ifdef UART_PARITY_EN
        TX_PAR:   tx_sn <= tx_par;
`endif
        default:  tx_sn <= 1'b1;
      endcase
    end
  end

  // ---------------- RX ----------------
  rx_state_t        rx_st;
  uart_cfg_t        rx_cfg;
  logic [DIV_W-1:0] rx_div;
  logic [DIV_W-1:0] rx_dcnt;
  logic [TW-1:0]    rx_tcnt;
  logic [7:0]       rx_sh;
  logic [2:0]       rx_bcnt;
  logic             rx_perr;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic             rx_fall;
  logic             rx_dend;
  logic             rx_samp;
  logic             rx_last;
  logic [RX_W-1:0]  rxf_wdata;
  logic [RX_W-1:0]  rxf_rdata;
  logic             rxf_push;
  logic             rxf_pop;
  logic             rxf_full;
  logic             rxf_empty;

  // two-flop synchroniser plus one stage of edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_sn;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_dend = (rx_dcnt == rx_div);
  assign rx_samp = rx_dend &&
                   (rx_tcnt == ((rx_st == RX_START) ? T_HALF
                                                    : T_LAST));
  assign rx_last  = (rx_bcnt == ({1'b0, rx_cfg.len} + 3'd4));
  assign rxf_push = (rx_st == RX_STOP) && rx_samp;
  assign rxf_pop  = rx_valid && rx_ready;

  // RX tick timing; the tick count restarts at every sample
  always_ff @(posedge clk) begin
    if (!rst_n || rx_st == RX_IDLE) begin
      rx_dcnt <= '0;
      rx_tcnt <= '0;
    end else if (rx_dend) begin
      rx_dcnt <= '0;
      rx_tcnt <= rx_samp ? '0 : rx_tcnt + 1'b1;
    end else begin
      rx_dcnt <= rx_dcnt + 1'b1;
    end
  end

  // RX frame sequencer with false-start rejection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_st   <= RX_IDLE;
      rx_cfg  <= '0;
      rx_div  <= '0;
      rx_sh   <= '0;
      rx_bcnt <= '0;
      rx_perr <= 1'b0;
    end else begin
      unique case (rx_st)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_st   <= RX_START;
            rx_cfg  <= cfg_in;
            rx_div  <= cfg_div;
            rx_sh   <= '0;
            rx_bcnt <= '0;
            rx_perr <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_samp)
            rx_st <= rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (rx_samp) begin
            rx_sh[rx_bcnt] <= rx_s2;
            rx_bcnt        <= rx_bcnt + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_last)
              rx_st <= rx_cfg.par_en ? RX_PAR : RX_STOP;
`else
            if (rx_last) rx_st <= RX_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (rx_samp) begin
            rx_perr <= rx_s2 ^ par_bit(rx_sh, rx_cfg.len,
                                       rx_cfg.par_odd);
            rx_st   <= RX_STOP;
          end
        end
`endif
        RX_STOP: if (rx_samp) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // entry pushed on the stop sample
  always_comb begin
    rxf_wdata          = '0;
    rxf_wdata[7:0]     = rx_sh;
    rxf_wdata[PAR_BIT] = rx_perr;
    rxf_wdata[FRM_BIT] = !rx_s2;
  end

  uart_sync_fifo #(
    .W     (RX_W),
    .DEPTH (DEPTH)
  ) u_rxf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rxf_push),
    .wr_data (rxf_wdata),
    .rd_en   (rxf_pop),
    .rd_data (rxf_rdata),
    .full    (rxf_full),
    .empty   (rxf_empty)
  );

  assign rx_valid   = !rxf_empty;
  assign rx_data    = rxf_empty ? 8'h00 : rxf_rdata[7:0];
  assign rx_frm_err = !rxf_empty && rxf_rdata[FRM_BIT];
`ifdef UART_PARITY_EN
  assign rx_par_err = !rxf_empty && rxf_rdata[PAR_BIT];
`else
  assign rx_par_err = 1'b0;
`endif

  // sticky drop flag; a new drop beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n)
      rx_ovf <= 1'b0;
    else if (rxf_push && rxf_full && !rxf_pop)
      rx_ovf <= 1'b1;
    else if (rx_ovf_clr)
      rx_ovf <= 1'b0;
  end

  logic unused_cfg;
`ifdef UART_PARITY_EN
  assign unused_cfg = tx_cfg.par_odd;
`else
  assign unused_cfg = ^{cfg_par_en, cfg_par_odd,
                        tx_cfg.par_en, tx_cfg.par_odd,
                        rx_cfg.par_en, rx_cfg.par_odd,
                        rxf_rdata[PAR_BIT]};
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed checks of TX framing, RX decode,
// overflow handling and reset behaviour.
`timescale 1ns/1ps
module tb_uart_fifo_core;

  localparam int DEPTH = 8;
  localparam int OVS   = 16;
  localparam int DIV_W = 12;
`ifdef UART_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_len;
  logic             cfg_par_en;
  logic             cfg_par_odd;
  logic             cfg_stop2;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_par_err;
  logic             rx_frm_err;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_ovf;
  logic             rx_ovf_clr;
  logic             tx_sn;
  logic             rx_sn;
  logic             tx_busy;
  logic             loop;
  logic             rx_drv;

  always #5 clk = ~clk;

  assign rx_sn = loop ? tx_sn : rx_drv;

  uart_fifo_core #(
    .DEPTH (DEPTH),
    .OVS   (OVS),
    .DIV_W (DIV_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_div     (cfg_div),
    .cfg_len     (cfg_len),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_par_err  (rx_par_err),
    .rx_frm_err  (rx_frm_err),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_ovf      (rx_ovf),
    .rx_ovf_clr  (rx_ovf_clr),
    .tx_sn       (tx_sn),
    .rx_sn       (rx_sn),
    .tx_busy     (tx_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] len,
                         input logic pen, input logic podd,
                         input logic s2);
    cfg_len     = len;
    cfg_par_en  = pen;
    cfg_par_odd = podd;
    cfg_stop2   = s2;
  endtask

  // each bit must hold its level for a full OVS clocks
  task automatic expect_bits(input string tag,
                             input logic [15:0] v,
                             input int n);
    int hits;
    for (int i = 0; i < n; i++) begin
      hits = 0;
      for (int c = 0; c < OVS; c++) begin
        if (tx_sn === v[i]) hits++;
        @(negedge clk);
      end
      check(tag, hits, OVS);
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input int nb,
                         input logic pon, input logic par,
                         input logic stop);
    rx_drv = 1'b0;
    repeat (OVS) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_drv = d[i];
      repeat (OVS) @(negedge clk);
    end
    if (PE && pon) begin
      rx_drv = par;
      repeat (OVS) @(negedge clk);
    end
    rx_drv = stop;
    repeat (OVS) @(negedge clk);
    rx_drv = 1'b1;
    repeat (OVS) @(negedge clk);
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] d,
                        input logic pe, input logic fe);
    for (int k = 0; k < 400 && !rx_valid; k++)
      @(negedge clk);
    check({tag, "_valid"}, rx_valid, 1'b1);
    check(tag, {rx_frm_err, rx_par_err, rx_data},
          {fe, pe, d});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  logic [15:0] v;
  int          nb;

  initial begin
    rst_n      = 1'b0;
    cfg_div    = '0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    rx_ovf_clr = 1'b0;
    rx_drv     = 1'b1;
    loop       = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    check("rst_tx_sn", tx_sn, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_par_err", rx_par_err, 1'b0);
    check("rst_frm_err", rx_frm_err, 1'b0);
    check("rst_ovf", rx_ovf, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    check("a5_lat1", tx_sn, 1'b1);
    @(negedge clk);
    check("a5_lat2", tx_sn, 1'b1);
    @(negedge clk);
    v = {1'b1, 8'hA5, 1'b0};
    expect_bits("a5_bit", v, 10);
    check("a5_busy_end", tx_busy, 1'b0);
    check("a5_idle", tx_sn, 1'b1);

    // 7E2 loopback, burst of three writes
    set_cfg(2'd2, 1'b1, 1'b0, 1'b1);
    loop     = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    @(negedge clk);
    tx_data  = 8'h33;
    @(negedge clk);
    tx_data  = 8'h0F;
    @(negedge clk);
    tx_valid = 1'b0;
`ifdef UART_PARITY_EN
    v  = {1'b0, 2'b11, 1'b0, 7'h5A, 1'b0};
    nb = 12;
`else
    v  = {1'b0, 2'b11, 7'h5A, 1'b0};
    nb = 11;
`endif
    expect_bits("burst_bit", v, nb);
    pop_rx("lb_5a", 8'h5A, 1'b0, 1'b0);
    pop_rx("lb_33", 8'h33, 1'b0, 1'b0);
    pop_rx("lb_0f", 8'h0F, 1'b0, 1'b0);
    loop = 1'b0;
    repeat (48) @(negedge clk);
    check("lb_busy_end", tx_busy, 1'b0);

    // RX 8O1: bad parity, then bad stop
    set_cfg(2'd3, 1'b1, 1'b1, 1'b0);
    rx_send(8'h00, 8, 1'b1, 1'b0, 1'b1);
    pop_rx("rx_par", 8'h00, PE, 1'b0);
    rx_send(8'h00, 8, 1'b1, 1'b1, 1'b0);
    pop_rx("rx_frm", 8'h00, 1'b0, 1'b1);

    // 5-clock glitch must not start a frame
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_push", rx_valid, 1'b0);
    rx_send(8'h3C, 8, 1'b1, 1'b1, 1'b1);
    pop_rx("post_glitch", 8'h3C, 1'b0, 1'b0);

    // overflow: DEPTH+1 frames with no pops
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= DEPTH; i++)
      rx_send(8'h30 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    check("ovf_valid", rx_valid, 1'b1);
    check("ovf_set", rx_ovf, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      pop_rx("ovf_entry", 8'h30 + 8'(i), 1'b0, 1'b0);
    check("ovf_drained", rx_valid, 1'b0);
    check("ovf_sticky", rx_ovf, 1'b1);
    rx_ovf_clr = 1'b1;
    @(negedge clk);
    rx_ovf_clr = 1'b0;
    check("ovf_clr", rx_ovf, 1'b0);

    // reset in the middle of a frame
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_low", tx_sn, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_sn", tx_sn, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    repeat (200) @(negedge clk);
    check("mid_rst_line", tx_sn, 1'b1);
    check("mid_rst_rx", rx_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
